// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: one shift-add or restoring-divide step per cycle.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero multiplies skip the BUSY phase.
module ex_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      stall,
    input  logic            flush,
    input  logic            md_en,
    input  logic [2:0]      md_op,
    input  logic [XLEN-1:0] md_r1_data,
    input  logic [XLEN-1:0] md_r2_data,
    output logic            md_stallreq,
    output logic            md_valid,
    output logic [XLEN-1:0] md_result
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              div_zero_q;
    logic [XLEN-1:0]   r1_q;
    logic [XLEN-1:0]   opb_q;
    // {hi, lo} of the running product, or {remainder, dividend/quotient} while dividing
    logic [2*XLEN-1:0] acc_q;

    logic              is_div, s1, s2, a_neg, b_neg, start;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              early;
    logic [XLEN-1:0]   early_res;
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_step, prod_signed;
    logic [XLEN-1:0]   quo, rem, final_res;

    // Only the EX-hold bit of the stall vector matters here.
    logic unused_bits;
    assign unused_bits = ^{stall[5:4], stall[2:0], div_diff[XLEN]};

    // Operand decode from ID/EX: iterate on magnitudes, fix the sign at the end.
    always_comb begin
        is_div = md_op[2];
        s1     = (md_op == OP_MULH) || (md_op == OP_MULHSU) || (md_op == OP_DIV) || (md_op == OP_REM);
        s2     = (md_op == OP_MULH) || (md_op == OP_DIV) || (md_op == OP_REM);
        a_neg  = s1 && md_r1_data[XLEN-1];
        b_neg  = s2 && md_r2_data[XLEN-1];
        abs_a  = a_neg ? -md_r1_data : md_r1_data;
        abs_b  = b_neg ? -md_r2_data : md_r2_data;
        start  = md_en && !flush;
    end

`ifdef MULDIV_EARLY_OUT_EN
    always_comb begin
        early     = 1'b1;
        early_res = '0;
        if (is_div && md_r2_data == '0)
            early_res = md_op[1] ? md_r1_data : '1;
        else if ((md_op == OP_DIV || md_op == OP_REM) && md_r1_data == INT_MIN && md_r2_data == '1)
            early_res = md_op[1] ? '0 : INT_MIN;
        else if (!is_div && (md_r1_data == '0 || md_r2_data == '0))
            early_res = '0;
        else
            early = 1'b0;
    end
`else
    assign early     = 1'b0;
    assign early_res = '0;
`endif

    // One iteration step plus the result that step would finalise.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        div_ge    = div_shift >= {1'b0, opb_q};
        if (op_q[2])
            acc_step = {div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
        else
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        prod_signed = neg_q ? -acc_step : acc_step;
        quo         = acc_step[XLEN-1:0];
        rem         = acc_step[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                      final_res = prod_signed[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_res = prod_signed[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             final_res = div_zero_q ? '1 : (neg_q ? -quo : quo);
            default:                     final_res = div_zero_q ? r1_q : (neg_q ? -rem : rem);
        endcase
    end

    // NOTE: state and data registers use non-blocking assignments so every
    // register samples the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        md_stallreq = 1'b0;
        md_valid    = 1'b0;
        case (state)
            IDLE: if (start) begin
                md_stallreq = 1'b1;
                state_nxt   = early ? DONE : BUSY;
            end
            BUSY: begin
                md_stallreq = 1'b1;
                if (cnt == CNT_W'(XLEN-1)) state_nxt = DONE;
            end
            DONE: begin
                md_valid = 1'b1;
                if (!stall[3]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (flush) begin
            state_nxt   = IDLE;
            md_stallreq = 1'b0;
            md_valid    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            op_q       <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            r1_q       <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            md_result  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q       <= md_op;
                    neg_q      <= (is_div && md_op[1]) ? a_neg : (a_neg ^ b_neg);
                    div_zero_q <= is_div && (md_r2_data == '0);
                    r1_q       <= md_r1_data;
                    opb_q      <= abs_b;
                    acc_q      <= {{XLEN{1'b0}}, abs_a};
                    cnt        <= '0;
                    if (early) md_result <= early_res;
                end
                BUSY: if (!flush) begin
                    acc_q <= acc_step;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN-1)) md_result <= final_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed vector table, random ops against an arithmetic model,
// and hand-written stall-hold, flush and reset-abort sequences.
module tb_ex_muldiv;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        md_en;
    logic [2:0]  md_op;
    logic [31:0] md_r1_data;
    logic [31:0] md_r2_data;
    logic        md_stallreq;
    logic        md_valid;
    logic [31:0] md_result;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    ex_muldiv dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .md_en      (md_en),
        .md_op      (md_op),
        .md_r1_data (md_r1_data),
        .md_r2_data (md_r2_data),
        .md_stallreq(md_stallreq),
        .md_valid   (md_valid),
        .md_result  (md_result)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    // RV32M semantics computed with plain 64-bit integer arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int              sa, sb;
        longint          p;
        longint unsigned pu;
        logic            ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
        case (op)
            3'd0: begin p = longint'(sa) * longint'(sb); return p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFFFFFF : ovf ? 32'h80000000 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Stall-request cycles expected before md_valid (capture cycle included).
    function automatic int exp_stall(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
        if ((op[2] && b == 0) ||
            ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) ||
            (!op[2] && (a == 0 || b == 0)))
            return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic add_vec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp, input string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    // Present an instruction in ID/EX and wait (bounded) for md_valid.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        @(negedge clk);
        md_en = 1'b1; md_op = op; md_r1_data = a; md_r2_data = b;
        #1;
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            if (md_valid) break;
            if (md_stallreq) cyc++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic release_op(input string name, input logic [31:0] exp);
        md_en = 1'b0;
        stall = '0;
        @(negedge clk);
        #1;
        check({name, " back to idle"}, {31'b0, md_valid}, 32'h0);
        check({name, " result held"}, md_result, exp);
    endtask

    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int cyc;
        run_op(op, a, b, cyc);
        check({name, " valid"}, {31'b0, md_valid}, 32'h1);
        check({name, " result"}, md_result, exp);
        check({name, " stall cycles"}, 32'(cyc), 32'(exp_stall(op, a, b)));
        check({name, " no stallreq in done"}, {31'b0, md_stallreq}, 32'h0);
        release_op(name, exp);
    endtask

    task automatic abort_seq(input bit use_rst);
        string nm;
        nm = use_rst ? "rst abort" : "flush abort";
        @(negedge clk);
        md_en = 1'b1; md_op = 3'd4; md_r1_data = 32'hFFFFFF9C; md_r2_data = 32'd7;
        repeat (11) @(negedge clk);
        if (use_rst) begin
            rst = 1'b1; md_en = 1'b0;
        end else begin
            flush = 1'b1;
            #1;
            check({nm, " stallreq same cycle"}, {31'b0, md_stallreq}, 32'h0);
            check({nm, " valid same cycle"}, {31'b0, md_valid}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; md_en = 1'b0;
        #1;
        check({nm, " stallreq after"}, {31'b0, md_stallreq}, 32'h0);
        check({nm, " valid after"}, {31'b0, md_valid}, 32'h0);
        if (use_rst) check({nm, " result reset"}, md_result, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        check({nm, " stays idle"}, {31'b0, md_stallreq}, 32'h0);
        do_op({nm, " then DIVU 9/3"}, 3'd5, 32'd9, 32'd3, 32'd3);
    endtask

    initial begin
        int          cyc;
        logic [31:0] exp, a, b;
        logic [2:0]  op;

        add_vec(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "MUL 7*-3");
        add_vec(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "MULH min*min");
        add_vec(3'd3, 32'h80000000, 32'h80000000, 32'h40000000, "MULHU 2^31*2^31");
        add_vec(3'd2, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, "MULHSU -1*2");
        add_vec(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "DIV -7/2");
        add_vec(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "REM -7%2");
        add_vec(3'd5, 32'd100,      32'd7,        32'd14,       "DIVU 100/7");
        add_vec(3'd7, 32'd100,      32'd7,        32'd2,        "REMU 100%7");
        add_vec(3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, "DIVU 5/0");
        add_vec(3'd6, 32'd5,        32'd0,        32'd5,        "REM 5%0");
        add_vec(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "DIV overflow");
        add_vec(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0,        "REM overflow");
        add_vec(3'd4, 32'd7,        32'd0,        32'hFFFFFFFF, "DIV 7/0");
        add_vec(3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, "REM -7%0");
        add_vec(3'd0, 32'h0,        32'h12345678, 32'h0,        "MUL 0*x");
        add_vec(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        "MULH -1*-1");
        add_vec(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "MULHU max*max");

        rst = 1'b1; stall = '0; flush = 1'b0; md_en = 1'b0;
        md_op = '0; md_r1_data = '0; md_r2_data = '0;
        repeat (3) @(negedge clk);
        check("reset valid", {31'b0, md_valid}, 32'h0);
        check("reset stallreq", {31'b0, md_stallreq}, 32'h0);
        check("reset result", md_result, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);

        // DONE held by a downstream stall: result and valid must not move.
        exp = 32'(32'd12345 * 32'd6789);
        run_op(3'd0, 32'd12345, 32'd6789, cyc);
        check("stall hold first valid", {31'b0, md_valid}, 32'h1);
        stall = 6'b001000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check($sformatf("stall hold valid %0d", i), {31'b0, md_valid}, 32'h1);
            check($sformatf("stall hold result %0d", i), md_result, exp);
        end
        release_op("stall hold", exp);

        abort_seq(1'b0);
        abort_seq(1'b1);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            do_op($sformatf("rand%0d op%0d %08h,%08h", i, op, a, b), op, a, b, ref_md(op, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
